// File: rtl/outport_alloc_pkg.sv
// outport_alloc_pkg: shared flit format, type codes and allocator FSM
// encodings used by the output-port allocator and its arbiter.
package outport_alloc_pkg;

  localparam int DATAW    = 31;
  localparam int VCHW     = 0;
  localparam int TYPEW    = 1;
  localparam int TYPE_MSB = DATAW;
  localparam int TYPE_LSB = DATAW - TYPEW;
  localparam int NPORT    = 5;

  localparam logic [TYPEW:0] TYPE_HEAD     = 2'b00;
  localparam logic [TYPEW:0] TYPE_BODY     = 2'b01;
  localparam logic [TYPEW:0] TYPE_TAIL     = 2'b10;
  localparam logic [TYPEW:0] TYPE_HEADTAIL = 2'b11;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01
  } state_t;

  function automatic logic [2:0] rr_next(
    input logic [2:0] p
  );
    return (p == 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/outport_alloc_rr_arb5.sv
// rr_arb5: combinational 5-way round-robin arbiter.
// Ports: req (requests), ptr (highest-priority index), gnt (one-hot winner).
module rr_arb5
  import outport_alloc_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] gnt
);

  logic [2:0] idx;

  // Walk from the farthest slot back to ptr so the
  // first requester at or after ptr overwrites last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      idx = 3'((int'(ptr) + k) % NPORT);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = Enable;
      end
    end
  end

endmodule

// File: rtl/outport_alloc.sv
// outport_alloc: output-port allocator, per-VC credit manager and flit mux.
// Ports: req/ovch/send/idata per input, grt per input, ilck/irdy/credit_in
// per VC, odata/osend/oovch output link, err sticky protocol error.
module outport_alloc
  import outport_alloc_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int NVCH     = 2,
  parameter int BUFDEPTH = 4
)(
  input  logic            clk,
  input  logic            rst_,
  input  logic            req_0,
  input  logic            req_1,
  input  logic            req_2,
  input  logic            req_3,
  input  logic            req_4,
  input  logic [VCHW:0]   ovch_0,
  input  logic [VCHW:0]   ovch_1,
  input  logic [VCHW:0]   ovch_2,
  input  logic [VCHW:0]   ovch_3,
  input  logic [VCHW:0]   ovch_4,
  input  logic            send_0,
  input  logic            send_1,
  input  logic            send_2,
  input  logic            send_3,
  input  logic            send_4,
  input  logic [DATAW:0]  idata_0,
  input  logic [DATAW:0]  idata_1,
  input  logic [DATAW:0]  idata_2,
  input  logic [DATAW:0]  idata_3,
  input  logic [DATAW:0]  idata_4,
  output logic            grt_0,
  output logic            grt_1,
  output logic            grt_2,
  output logic            grt_3,
  output logic            grt_4,
  output logic [NVCH-1:0] ilck,
  output logic [NVCH-1:0] irdy,
  input  logic [NVCH-1:0] credit_in,
  output logic [DATAW:0]  odata,
  output logic            osend,
  output logic [VCHW:0]   oovch,
  output logic            err
);

  localparam int CW = $clog2(BUFDEPTH + 1);

  // Identifiers are informational; block only
  // exists for an impossible configuration.
  if (ROUTERID < 0 || PCHID < 0) begin : g_bad_id
  end

  logic [4:0]     req_v, send_v, cand, win;
  logic [VCHW:0]  ovch_a [NPORT];
  logic [DATAW:0] idata_a [NPORT];

  assign req_v  = {req_4, req_3, req_2, req_1, req_0};
  assign send_v = {send_4, send_3, send_2, send_1, send_0};
  assign ovch_a = '{ovch_0, ovch_1, ovch_2, ovch_3, ovch_4};
  assign idata_a = '{idata_0, idata_1, idata_2, idata_3, idata_4};

  state_t         state_q, state_n;
  logic [2:0]     owner_q, owner_n;
  logic [2:0]     rr_q, rr_n;
  logic [VCHW:0]  vc_q, vc_n;
  logic [4:0]     grt_q, grt_n;
  logic [NVCH-1:0] lck_q, lck_n;
  logic [NVCH-1:0] dec, ovf;
  logic [DATAW:0] od_q, od_n;
  logic           os_q, os_n;
  logic [VCHW:0]  oov_q, oov_n;
  logic           err_q, err_n;
  logic           fst_q, fst_n;
  logic           ow_send;
  logic [DATAW:0] ow_data;
  logic [TYPEW:0] ftype;

  for (genvar v = 0; v < NVCH; v++) begin : g_credit
    logic [CW-1:0] cnt;
    logic          inc;
    assign inc = credit_in[v];
    always_ff @(posedge clk or posedge rst_) begin
      if (rst_)
        cnt <= CW'(BUFDEPTH);
      else if (inc && !dec[v]) begin
        if (cnt != CW'(BUFDEPTH))
          cnt <= cnt + CW'(1);
      end else if (!inc && dec[v])
        cnt <= cnt - CW'(1);
    end
    assign ovf[v]  = inc & !dec[v] & (cnt == CW'(BUFDEPTH));
    assign irdy[v] = (cnt != '0);
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < NPORT; i++)
      cand[i] = req_v[i] & !lck_q[ovch_a[i]]
              & irdy[ovch_a[i]];
  end

  rr_arb5 u_arb (
    .req (cand),
    .ptr (rr_q),
    .gnt (win)
  );

  assign ow_send = send_v[owner_q];
  assign ow_data = idata_a[owner_q];
  assign ftype   = ow_data[TYPE_MSB:TYPE_LSB];

  always_comb begin
    state_n = state_q;
    owner_n = owner_q;
    vc_n    = vc_q;
    grt_n   = grt_q;
    lck_n   = lck_q;
    rr_n    = rr_q;
    od_n    = od_q;
    os_n    = Disable;
    oov_n   = oov_q;
    err_n   = err_q | (|ovf);
    fst_n   = fst_q;
    dec     = '0;
    unique case (state_q)
      IDLE: begin
        if (|win) begin
          for (int i = 0; i < NPORT; i++)
            if (win[i]) begin
              owner_n = 3'(i);
              vc_n    = ovch_a[i];
            end
          grt_n       = win;
          lck_n[vc_n] = Enable;
          fst_n       = Disable;
          state_n     = BUSY;
        end
      end
      BUSY: begin
        if (ow_send) begin
          if (irdy[vc_q]) begin
            od_n      = ow_data;
            os_n      = Enable;
            oov_n     = vc_q;
            dec[vc_q] = Enable;
            fst_n     = Enable;
          end else
            err_n = Enable;
          // A second head inside one packet is a framing error.
          if (fst_q && ftype == TYPE_HEAD)
            err_n = Enable;
          if (ftype == TYPE_TAIL ||
              ftype == TYPE_HEADTAIL) begin
            grt_n       = '0;
            lck_n[vc_q] = Disable;
            rr_n        = rr_next(owner_q);
            fst_n       = Disable;
            state_n     = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      vc_q    <= '0;
      grt_q   <= '0;
      lck_q   <= '0;
      od_q    <= '0;
      os_q    <= Disable;
      oov_q   <= '0;
      err_q   <= Disable;
      fst_q   <= Disable;
    end else begin
      state_q <= state_n;
      owner_q <= owner_n;
      rr_q    <= rr_n;
      vc_q    <= vc_n;
      grt_q   <= grt_n;
      lck_q   <= lck_n;
      od_q    <= od_n;
      os_q    <= os_n;
      oov_q   <= oov_n;
      err_q   <= err_n;
      fst_q   <= fst_n;
    end
  end

  assign {grt_4, grt_3, grt_2, grt_1, grt_0} = grt_q;
  assign ilck  = lck_q;
  assign odata = od_q;
  assign osend = os_q;
  assign oovch = oov_q;
  assign err   = err_q;

endmodule

// File: tb/tb_outport_alloc.sv
// tb_outport_alloc: directed self-checking bench for outport_alloc.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_outport_alloc;
  import outport_alloc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_;
  logic [4:0]     req, send;
  logic [VCHW:0]  ovch [5];
  logic [DATAW:0] idata [5];
  logic [1:0]     credit_in;
  wire  [4:0]     grt;
  wire  [1:0]     ilck, irdy;
  wire  [DATAW:0] odata;
  wire            osend;
  wire  [VCHW:0]  oovch;
  wire            err;

  int checks = 0;
  int errors = 0;

  outport_alloc #(
    .ROUTERID (0),
    .PCHID    (0),
    .NVCH     (2),
    .BUFDEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .req_0     (req[0]),
    .req_1     (req[1]),
    .req_2     (req[2]),
    .req_3     (req[3]),
    .req_4     (req[4]),
    .ovch_0    (ovch[0]),
    .ovch_1    (ovch[1]),
    .ovch_2    (ovch[2]),
    .ovch_3    (ovch[3]),
    .ovch_4    (ovch[4]),
    .send_0    (send[0]),
    .send_1    (send[1]),
    .send_2    (send[2]),
    .send_3    (send[3]),
    .send_4    (send[4]),
    .idata_0   (idata[0]),
    .idata_1   (idata[1]),
    .idata_2   (idata[2]),
    .idata_3   (idata[3]),
    .idata_4   (idata[4]),
    .grt_0     (grt[0]),
    .grt_1     (grt[1]),
    .grt_2     (grt[2]),
    .grt_3     (grt[3]),
    .grt_4     (grt[4]),
    .ilck      (ilck),
    .irdy      (irdy),
    .credit_in (credit_in),
    .odata     (odata),
    .osend     (osend),
    .oovch     (oovch),
    .err       (err)
  );

  function automatic logic [DATAW:0] flit(
    input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction

  task automatic clear_inputs();
    req = '0;
    send = '0;
    credit_in = '0;
    for (int i = 0; i < 5; i++) begin
      ovch[i] = '0;
      idata[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_ = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++; if (grt !== 5'b0) begin errors++; $display("FAIL rst_grt got=%b exp=%b", grt, 5'b0); end
    checks++; if (ilck !== 2'b00) begin errors++; $display("FAIL rst_ilck got=%b exp=%b", ilck, 2'b00); end
    checks++; if (irdy !== 2'b11) begin errors++; $display("FAIL rst_irdy got=%b exp=%b", irdy, 2'b11); end
    checks++; if (osend !== 1'b0) begin errors++; $display("FAIL rst_osend got=%b exp=0", osend); end
    checks++; if (odata !== 32'h0) begin errors++; $display("FAIL rst_odata got=%h exp=0", odata); end
    checks++; if (oovch !== 1'b0) begin errors++; $display("FAIL rst_oovch got=%b exp=0", oovch); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
    rst_ = 1'b0;
    @(negedge clk);
    checks++; if (grt !== 5'b0) begin errors++; $display("FAIL idle_grt got=%b exp=%b", grt, 5'b0); end
  endtask

  task automatic test_single_packet();
    do_reset();
    req[2] = 1'b1;
    ovch[2] = 1'b1;
    checks++; if (grt !== 5'b0) begin errors++; $display("FAIL sp_pregrt got=%b exp=%b", grt, 5'b0); end
    @(negedge clk);
    checks++; if (grt !== 5'b00100) begin errors++; $display("FAIL sp_grt got=%b exp=%b", grt, 5'b00100); end
    checks++; if (ilck !== 2'b10) begin errors++; $display("FAIL sp_lck got=%b exp=%b", ilck, 2'b10); end
    req[2] = 1'b0;
    send[2] = 1'b1;
    idata[2] = flit(TYPE_HEAD, 30'h11);
    @(negedge clk);
    checks++; if (osend !== 1'b1) begin errors++; $display("FAIL sp_os_h got=%b exp=1", osend); end
    checks++; if (odata !== flit(TYPE_HEAD, 30'h11)) begin errors++; $display("FAIL sp_od_h got=%h exp=%h", odata, flit(TYPE_HEAD, 30'h11)); end
    checks++; if (oovch !== 1'b1) begin errors++; $display("FAIL sp_vc_h got=%b exp=1", oovch); end
    checks++; if (grt !== 5'b00100) begin errors++; $display("FAIL sp_grt_h got=%b exp=%b", grt, 5'b00100); end
    idata[2] = flit(TYPE_BODY, 30'h22);
    @(negedge clk);
    checks++; if (odata !== flit(TYPE_BODY, 30'h22)) begin errors++; $display("FAIL sp_od_b got=%h exp=%h", odata, flit(TYPE_BODY, 30'h22)); end
    checks++; if (ilck !== 2'b10) begin errors++; $display("FAIL sp_lck_b got=%b exp=%b", ilck, 2'b10); end
    idata[2] = flit(TYPE_TAIL, 30'h33);
    @(negedge clk);
    checks++; if (odata !== flit(TYPE_TAIL, 30'h33)) begin errors++; $display("FAIL sp_od_t got=%h exp=%h", odata, flit(TYPE_TAIL, 30'h33)); end
    checks++; if (osend !== 1'b1) begin errors++; $display("FAIL sp_os_t got=%b exp=1", osend); end
    checks++; if (grt !== 5'b0) begin errors++; $display("FAIL sp_rel_grt got=%b exp=%b", grt, 5'b0); end
    checks++; if (ilck !== 2'b00) begin errors++; $display("FAIL sp_rel_lck got=%b exp=%b", ilck, 2'b00); end
    checks++; if (irdy !== 2'b11) begin errors++; $display("FAIL sp_irdy got=%b exp=%b", irdy, 2'b11); end
    send[2] = 1'b0;
    @(negedge clk);
    checks++; if (osend !== 1'b0) begin errors++; $display("FAIL sp_os_idle got=%b exp=0", osend); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sp_err got=%b exp=0", err); end
    // One credit left on VC1: a single-flit packet drains it.
    req[2] = 1'b1;
    @(negedge clk);
    checks++; if (grt !== 5'b00100) begin errors++; $display("FAIL sp_grt2 got=%b exp=%b", grt, 5'b00100); end
    req[2] = 1'b0;
    send[2] = 1'b1;
    idata[2] = flit(TYPE_HEADTAIL, 30'h44);
    @(negedge clk);
    send[2] = 1'b0;
    checks++; if (osend !== 1'b1) begin errors++; $display("FAIL sp_os_ht got=%b exp=1", osend); end
    checks++; if (irdy !== 2'b01) begin errors++; $display("FAIL sp_cred1 got=%b exp=%b", irdy, 2'b01); end
    checks++; if (grt !== 5'b0) begin errors++; $display("FAIL sp_rel2 got=%b exp=%b", grt, 5'b0); end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_g [4];
    exp_g = '{5'b00001, 5'b01000, 5'b00001, 5'b01000};
    do_reset();
    req[0] = 1'b1;
    req[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (grt !== exp_g[k]) begin errors++; $display("FAIL rr_grt%0d got=%b exp=%b", k, grt, exp_g[k]); end
      send = exp_g[k];
      idata[0] = flit(TYPE_HEADTAIL, 30'(k));
      idata[3] = flit(TYPE_HEADTAIL, 30'(k + 8));
      credit_in = 2'b01;
      @(negedge clk);
      send = '0;
      credit_in = '0;
      checks++; if (grt !== 5'b0) begin errors++; $display("FAIL rr_gap%0d got=%b exp=%b", k, grt, 5'b0); end
      checks++; if (osend !== 1'b1) begin errors++; $display("FAIL rr_os%0d got=%b exp=1", k, osend); end
      checks++; if (odata !== flit(TYPE_HEADTAIL, 30'(exp_g[k][0] ? k : k + 8))) begin errors++; $display("FAIL rr_od%0d got=%h", k, odata); end
      checks++; if (ilck !== 2'b00) begin errors++; $display("FAIL rr_lck%0d got=%b exp=%b", k, ilck, 2'b00); end
    end
    req = '0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rr_err got=%b exp=0", err); end
    checks++; if (irdy !== 2'b11) begin errors++; $display("FAIL rr_irdy got=%b exp=%b", irdy, 2'b11); end
  endtask

  task automatic test_credit_exhaust();
    logic [1:0] ty [4];
    ty = '{TYPE_HEAD, TYPE_BODY, TYPE_BODY, TYPE_TAIL};
    do_reset();
    req[1] = 1'b1;
    @(negedge clk);
    checks++; if (grt !== 5'b00010) begin errors++; $display("FAIL ce_grt got=%b exp=%b", grt, 5'b00010); end
    req[1] = 1'b0;
    send[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idata[1] = flit(ty[k], 30'(k + 1));
      @(negedge clk);
      checks++; if (osend !== 1'b1) begin errors++; $display("FAIL ce_os%0d got=%b exp=1", k, osend); end
      if (k == 2) begin
        checks++; if (irdy !== 2'b11) begin errors++; $display("FAIL ce_irdy3 got=%b exp=%b", irdy, 2'b11); end
      end
    end
    send[1] = 1'b0;
    checks++; if (irdy !== 2'b10) begin errors++; $display("FAIL ce_empty got=%b exp=%b", irdy, 2'b10); end
    req[4] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (grt !== 5'b0) begin errors++; $display("FAIL ce_nogrt%0d got=%b exp=%b", k, grt, 5'b0); end
    end
    credit_in = 2'b01;
    @(negedge clk);
    credit_in = '0;
    checks++; if (irdy !== 2'b11) begin errors++; $display("FAIL ce_ret got=%b exp=%b", irdy, 2'b11); end
    checks++; if (grt !== 5'b0) begin errors++; $display("FAIL ce_ret_grt got=%b exp=%b", grt, 5'b0); end
    @(negedge clk);
    checks++; if (grt !== 5'b10000) begin errors++; $display("FAIL ce_grt4 got=%b exp=%b", grt, 5'b10000); end
    checks++; if (ilck !== 2'b01) begin errors++; $display("FAIL ce_lck got=%b exp=%b", ilck, 2'b01); end
  endtask

  // Continues the packet granted at the end of test_credit_exhaust.
  task automatic test_simultaneous();
    req[4] = 1'b0;
    send[4] = 1'b1;
    idata[4] = flit(TYPE_HEAD, 30'h51);
    credit_in = 2'b01;
    @(negedge clk);
    credit_in = '0;
    checks++; if (osend !== 1'b1) begin errors++; $display("FAIL si_os got=%b exp=1", osend); end
    checks++; if (irdy !== 2'b11) begin errors++; $display("FAIL si_same got=%b exp=%b", irdy, 2'b11); end
    idata[4] = flit(TYPE_BODY, 30'h52);
    @(negedge clk);
    checks++; if (irdy !== 2'b10) begin errors++; $display("FAIL si_zero got=%b exp=%b", irdy, 2'b10); end
    idata[4] = flit(TYPE_TAIL, 30'h53);
    @(negedge clk);
    send[4] = 1'b0;
    checks++; if (osend !== 1'b0) begin errors++; $display("FAIL si_drop got=%b exp=0", osend); end
    checks++; if (odata !== flit(TYPE_BODY, 30'h52)) begin errors++; $display("FAIL si_hold got=%h exp=%h", odata, flit(TYPE_BODY, 30'h52)); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL si_err got=%b exp=1", err); end
    checks++; if (grt !== 5'b0) begin errors++; $display("FAIL si_rel got=%b exp=%b", grt, 5'b0); end
    checks++; if (ilck !== 2'b00) begin errors++; $display("FAIL si_lck got=%b exp=%b", ilck, 2'b00); end
  endtask

  task automatic test_credit_overflow();
    do_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ov_pre got=%b exp=0", err); end
    credit_in = 2'b01;
    @(negedge clk);
    credit_in = '0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ov_err got=%b exp=1", err); end
    checks++; if (irdy !== 2'b11) begin errors++; $display("FAIL ov_irdy got=%b exp=%b", irdy, 2'b11); end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ov_sticky got=%b exp=1", err); end
  endtask

  task automatic test_head_err();
    do_reset();
    req[0] = 1'b1;
    ovch[0] = 1'b1;
    @(negedge clk);
    checks++; if (grt !== 5'b00001) begin errors++; $display("FAIL he_grt got=%b exp=%b", grt, 5'b00001); end
    req[0] = 1'b0;
    send[0] = 1'b1;
    idata[0] = flit(TYPE_HEAD, 30'h61);
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL he_first got=%b exp=0", err); end
    idata[0] = flit(TYPE_HEAD, 30'h62);
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL he_second got=%b exp=1", err); end
    checks++; if (osend !== 1'b1) begin errors++; $display("FAIL he_os got=%b exp=1", osend); end
    idata[0] = flit(TYPE_TAIL, 30'h63);
    @(negedge clk);
    send[0] = 1'b0;
    checks++; if (grt !== 5'b0) begin errors++; $display("FAIL he_rel got=%b exp=%b", grt, 5'b0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req[2] = 1'b1;
    ovch[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    send[2] = 1'b1;
    idata[2] = flit(TYPE_HEAD, 30'h71);
    @(negedge clk);
    idata[2] = flit(TYPE_BODY, 30'h72);
    @(negedge clk);
    send[2] = 1'b0;
    checks++; if (odata !== flit(TYPE_BODY, 30'h72)) begin errors++; $display("FAIL rm_body got=%h", odata); end
    checks++; if (ilck !== 2'b10) begin errors++; $display("FAIL rm_lck_pre got=%b exp=%b", ilck, 2'b10); end
    #2 rst_ = 1'b1;
    #1;
    checks++; if (grt !== 5'b0) begin errors++; $display("FAIL rm_grt got=%b exp=%b", grt, 5'b0); end
    checks++; if (ilck !== 2'b00) begin errors++; $display("FAIL rm_lck got=%b exp=%b", ilck, 2'b00); end
    checks++; if (irdy !== 2'b11) begin errors++; $display("FAIL rm_irdy got=%b exp=%b", irdy, 2'b11); end
    checks++; if (osend !== 1'b0) begin errors++; $display("FAIL rm_os got=%b exp=0", osend); end
    checks++; if (odata !== 32'h0) begin errors++; $display("FAIL rm_od got=%h exp=0", odata); end
    @(negedge clk);
    rst_ = 1'b0;
    req[0] = 1'b1;
    req[2] = 1'b1;
    ovch[0] = 1'b1;
    ovch[2] = 1'b1;
    @(negedge clk);
    checks++; if (grt !== 5'b00001) begin errors++; $display("FAIL rm_idle got=%b exp=%b", grt, 5'b00001); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_credit_exhaust();
    test_simultaneous();
    test_credit_overflow();
    test_head_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
